// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch queue feeding the IF/ID register.
// Issues sequential word fetches and tolerates variable in-order response latency.
// Buffers up to DEPTH {pc, instruction} pairs for a valid/ready consumer.
// A redirect flushes the queue; responses still in flight at that point are dropped.
module inst_prefetch_buffer #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     IW       = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [IW-1:0]   imem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IW-1:0]   ir_out,
  output logic [XLEN-1:0] pc_out,
  output logic            err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_X = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] ONE_P   = AW'(1);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [AW-1:0]   tag_wr_q, tag_rd_q;
  logic            err_q;

  logic [IW-1:0]   ir_mem_q  [DEPTH];
  logic [XLEN-1:0] pc_mem_q  [DEPTH];
  logic [XLEN-1:0] tag_mem_q [DEPTH];

  logic            rsp_ok;
  logic            rsp_bad;
  logic            rsp_keep;
  logic            req_fire;
  logic            pop;
  logic [CW:0]     occ;

  // Handshake qualifiers and the issue rule (entries already queued or still owed).
  always_comb begin
    rsp_ok   = imem_rsp_valid & (inflight_q != '0);
    rsp_bad  = imem_rsp_valid & (inflight_q == '0);
    // drop never exceeds inflight, so this cannot underflow
    occ      = {1'b0, count_q} + {1'b0, inflight_q} - {1'b0, drop_q};
    imem_req_valid = (state_q != BOOT) & ~redirect & (inflight_q < DEPTH_C) & (occ < DEPTH_X);
    imem_req_addr  = fetch_pc_q;
    req_fire = imem_req_valid & imem_req_ready;
    // data arriving in a redirect cycle or while draining is stale
    rsp_keep = rsp_ok & ~redirect & (drop_q == '0);
    pop      = (count_q != '0) & out_ready & ~redirect;
  end

  // Next-state for counters, pointers, fetch PC and FSM; redirect overrides everything.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;

    if (req_fire) inflight_d = inflight_d + ONE_C;
    if (rsp_ok)   inflight_d = inflight_d - ONE_C;

    if (redirect) begin
      fetch_pc_d = redirect_pc & ~XLEN'(3);
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      // no request issues in a redirect cycle, so only the response can retire one
      drop_d     = rsp_ok ? (inflight_q - ONE_C) : inflight_q;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (rsp_ok && (drop_q != '0)) drop_d = drop_q - ONE_C;
      if (rsp_keep) begin
        count_d = count_d + ONE_C;
        tail_d  = tail_q + ONE_P;
      end
      if (pop) begin
        count_d = count_d - ONE_C;
        head_d  = head_q + ONE_P;
      end
    end

    unique case (state_q)
      BOOT:        state_d = RUN;
      RUN, DRAIN:  state_d = (drop_d != '0) ? DRAIN : RUN;
      default:     state_d = BOOT;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      if (rsp_bad) err_q <= 1'b1;
    end
  end

  // PC tag FIFO: one entry per accepted request, consumed by its response.
  // Pointers survive a redirect so stale responses still retire their own tags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) tag_mem_q[i] <= '0;
    end else begin
      if (req_fire) begin
        tag_mem_q[tag_wr_q] <= fetch_pc_q;
        tag_wr_q            <= tag_wr_q + ONE_P;
      end
      if (rsp_ok) tag_rd_q <= tag_rd_q + ONE_P;
    end
  end

  // Instruction queue storage; head entry drives the outputs directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ir_mem_q[i] <= '0;
        pc_mem_q[i] <= '0;
      end
    end else if (rsp_keep) begin
      ir_mem_q[tail_q] <= imem_rsp_data;
      pc_mem_q[tail_q] <= tag_mem_q[tag_rd_q];
    end
  end

  // Registered outputs from queue head.
  always_comb begin
    out_valid = (count_q != '0);
    ir_out    = ir_mem_q[head_q];
    pc_out    = pc_mem_q[head_q];
    err       = err_q;
  end

  // Occupancy invariants guaranteed by the issue rule.
  a_count_max : assert property (@(posedge clk) disable iff (!rst) count_q <= DEPTH_C);
  a_infl_max  : assert property (@(posedge clk) disable iff (!rst) inflight_q <= DEPTH_C);
  a_drop_max  : assert property (@(posedge clk) disable iff (!rst) drop_q <= inflight_q);
  a_no_ovf    : assert property (@(posedge clk) disable iff (!rst)
                                 !(rsp_keep && !pop && count_q == DEPTH_C));

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Directed bench for inst_prefetch_buffer with an in-order memory model and PC scoreboard.
module tb_inst_prefetch_buffer;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned IW    = 32;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b0;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [IW-1:0]   imem_rsp_data = '0;
  logic            redirect = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [IW-1:0]   ir_out;
  logic [XLEN-1:0] pc_out;
  logic            err;

  inst_prefetch_buffer #(
    .XLEN     (XLEN),
    .IW       (IW),
    .DEPTH    (DEPTH),
    .RESET_PC (64'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .ir_out         (ir_out),
    .pc_out         (pc_out),
    .err            (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int unsigned due;
  } pend_t;

  pend_t       pend[$];
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  int unsigned pops = 0;
  int unsigned n_req = 0;
  int          outstanding = 0;
  int          max_out = 0;
  int unsigned lat_fix = 1;
  bit          rand_lat = 1'b0;
  bit          rand_mode = 1'b0;
  bit          model_en = 1'b1;
  bit          rsp_from_model = 1'b0;
  bit          post_redir = 1'b0;
  logic [63:0] exp_pc = '0;
  logic        s_req_valid, s_hs, s_pop;
  logic [63:0] s_addr, s_pop_pc;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0013;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  // One clock: sample at negedge, update memory model and drive inputs at posedge+1.
  task automatic cycle();
    int unsigned l;
    @(negedge clk);
    if (post_redir) begin
      check_eq("out_valid_after_redirect", {63'd0, out_valid}, 64'd0);
      post_redir = 1'b0;
    end
    s_req_valid = imem_req_valid;
    s_hs        = imem_req_valid & imem_req_ready;
    s_addr      = imem_req_addr;
    s_pop       = 1'b0;
    if (redirect) begin
      exp_pc     = redirect_pc & ~64'h3;
      post_redir = 1'b1;
    end else if (out_valid && out_ready) begin
      check_eq("pop_pc", pc_out, exp_pc);
      check_eq("pop_ir", {32'd0, ir_out}, {32'd0, mem_word(exp_pc)});
      s_pop    = 1'b1;
      s_pop_pc = pc_out;
      exp_pc   = exp_pc + 64'd4;
      pops++;
    end
    if (s_hs) n_req++;
    @(posedge clk);
    #1;
    cyc++;
    if (rsp_from_model && imem_rsp_valid) outstanding--;
    if (s_hs) begin
      l = rand_lat ? $urandom_range(1, 3) : lat_fix;
      pend.push_back('{s_addr, cyc + l - 1});
      outstanding++;
    end
    if (outstanding > max_out) max_out = outstanding;
    if (model_en) begin
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend[0].addr);
        void'(pend.pop_front());
        rsp_from_model = 1'b1;
      end else begin
        imem_rsp_valid = 1'b0;
        rsp_from_model = 1'b0;
      end
    end else begin
      rsp_from_model = 1'b0;
    end
    if (rand_mode) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      out_ready      = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    check_eq({tag, "_req_valid"}, {63'd0, imem_req_valid}, 64'd0);
    check_eq({tag, "_ir_out"}, {32'd0, ir_out}, 64'd0);
    check_eq({tag, "_pc_out"}, pc_out, 64'd0);
    check_eq({tag, "_err"}, {63'd0, err}, 64'd0);
  endtask

  // Hold reset for two edges, check reset values, release at posedge+1.
  task automatic do_reset();
    rst            = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect       = 1'b0;
    rsp_from_model = 1'b0;
    pend.delete();
    outstanding    = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    exp_pc     = 64'h0;
    post_redir = 1'b0;
    rst        = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned p0;
    bit found;

    // 1: streaming at 1-cycle latency
    do_reset();
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    lat_fix        = 1;
    cycle();
    check_eq("boot_no_req", {63'd0, s_req_valid}, 64'd0);
    cycle();
    check_eq("first_req_valid", {63'd0, s_req_valid}, 64'd1);
    check_eq("first_req_addr", s_addr, 64'h0);
    repeat (6) cycle();
    p0 = pops;
    repeat (12) cycle();
    check_eq("throughput", 64'(pops - p0), 64'd12);

    // 2: consumer stalled, queue fills to DEPTH and holds
    do_reset();
    out_ready = 1'b0;
    n_req     = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (i >= 6) begin
        check_eq("hold_valid", {63'd0, out_valid}, 64'd1);
        check_eq("hold_pc", pc_out, 64'h0);
        check_eq("hold_ir", {32'd0, ir_out}, {32'd0, mem_word(64'h0)});
      end
    end
    check_eq("stall_req_count", 64'(n_req), 64'(DEPTH));
    out_ready = 1'b1;
    p0 = pops;
    repeat (8) cycle();
    check_eq("drain_after_stall", {63'd0, (pops - p0) >= 5}, 64'd1);

    // 3: redirect with three requests in flight at 3-cycle latency
    do_reset();
    lat_fix = 3;
    found   = 1'b0;
    repeat (4) cycle();
    for (int i = 0; i < 50 && !found; i++) begin
      cycle();
      if (outstanding == 3) found = 1'b1;
    end
    check_eq("t3_three_inflight", {63'd0, found}, 64'd1);
    redirect    = 1'b1;
    redirect_pc = 64'h100;
    cycle();
    redirect = 1'b0;
    p0 = pops;
    for (int i = 0; i < 50 && pops == p0; i++) cycle();
    check_eq("t3_first_pc", s_pop_pc, 64'h100);

    // 4: redirect coinciding with a response and an output pop
    do_reset();
    lat_fix = 2;
    found   = 1'b0;
    repeat (8) cycle();
    for (int i = 0; i < 50 && !found; i++) begin
      cycle();
      if (imem_rsp_valid && out_valid && outstanding == 2) found = 1'b1;
    end
    check_eq("t4_setup", {63'd0, found}, 64'd1);
    redirect    = 1'b1;
    redirect_pc = 64'h203;
    p0 = pops;
    cycle();
    redirect = 1'b0;
    check_eq("t4_pop_ignored", 64'(pops - p0), 64'd0);
    for (int i = 0; i < 50 && pops == p0; i++) cycle();
    check_eq("t4_first_pc", s_pop_pc, 64'h200);

    // 5: random backpressure, latency and redirects
    rand_lat  = 1'b1;
    rand_mode = 1'b1;
    max_out   = 0;
    p0 = pops;
    for (int i = 0; i < 30000 && (pops - p0) < 1000; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        redirect    = 1'b1;
        redirect_pc = {$urandom(), $urandom()};
        cycle();
        redirect = 1'b0;
      end else begin
        cycle();
      end
    end
    check_eq("t5_instr_count", {63'd0, (pops - p0) >= 1000}, 64'd1);
    check_eq("t5_inflight_bound", {63'd0, max_out <= DEPTH}, 64'd1);
    rand_lat       = 1'b0;
    rand_mode      = 1'b0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;

    // 6: spurious response, reset mid-burst, late response after reset
    do_reset();
    imem_req_ready = 1'b0;
    cycle();
    cycle();
    model_en       = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    cycle();
    imem_rsp_valid = 1'b0;
    cycle();
    check_eq("t6_err_set", {63'd0, err}, 64'd1);
    check_eq("t6_queue_empty", {63'd0, out_valid}, 64'd0);
    model_en       = 1'b1;
    imem_req_ready = 1'b1;
    lat_fix        = 2;
    repeat (6) cycle();
    #2;
    rst            = 1'b0;
    imem_rsp_valid = 1'b0;
    rsp_from_model = 1'b0;
    pend.delete();
    outstanding = 0;
    #1;
    check_reset_outputs("midreset");
    model_en = 1'b0;
    cycle();
    cycle();
    rst            = 1'b1;
    exp_pc         = 64'h0;
    post_redir     = 1'b0;
    imem_rsp_valid = 1'b1;
    cycle();
    imem_rsp_valid = 1'b0;
    cycle();
    check_eq("t6_late_rsp_err", {63'd0, err}, 64'd1);
    model_en = 1'b1;
    do_reset();
    cycle();
    cycle();
    check_eq("restart_req_valid", {63'd0, s_req_valid}, 64'd1);
    check_eq("restart_req_addr", s_addr, 64'h0);
    p0 = pops;
    repeat (10) cycle();
    check_eq("restart_stream", {63'd0, (pops - p0) >= 5}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
